// File: rtl/dmem_bridge.sv
// dmem_bridge: data-memory bridge between the single-cycle MIPS core and a
// multi-cycle request/acknowledge data bus. Holds the core with stall while a
// load or store is in flight; an 8-bit watchdog bounds every bus transaction.
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject misaligned accesses
// without touching the bus (err pulse, ERRDATA returned for loads).
module dmem_bridge #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] ERRDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Last watchdog value before giving up on the bus.
  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [31:0] rdata_reg, rdata_next;
  logic [7:0]  count_reg, count_next;
  logic        err_reg, err_next;
  logic        access;
  logic        misaligned;

  assign access = memread | memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // State and datapath registers; reset forces IDLE so bus_req drops at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      rdata_reg <= rdata_next;
      count_reg <= count_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath update; err is only ever set on entry to DONE.
  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    rdata_next = rdata_reg;
    count_next = count_reg;
    err_next   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (access) begin
          // memwrite wins when both strobes are high
          we_next    = memwrite;
          addr_next  = addr;
          wdata_next = wdata;
          count_next = '0;
          if (misaligned) begin
            state_next = DONE;
            err_next   = 1'b1;
            if (!memwrite) rdata_next = ERRDATA;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        // ack takes priority over a coinciding watchdog expiry
        if (bus_ack) begin
          state_next = DONE;
          if (!we_reg) rdata_next = bus_rdata;
        end else if (count_reg == LAST_COUNT) begin
          state_next = DONE;
          err_next   = 1'b1;
          if (!we_reg) rdata_next = ERRDATA;
        end else begin
          count_next = count_reg + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Core-side and bus-side outputs; bus fields come only from latched values.
  always_comb begin
    stall     = ((state_reg == IDLE) && access) || (state_reg == REQ);
    bus_req   = (state_reg == REQ);
    bus_we    = we_reg;
    bus_addr  = {addr_reg[31:2], 2'b00};
    bus_wdata = wdata_reg;
    rdata     = rdata_reg;
    err       = err_reg;
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed scoreboard bench for dmem_bridge. The driver pushes
// the expected outcome of each access into a queue; the monitor pops and
// compares when it sees the completion (DONE) cycle.
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          reqs;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
  } exp_t;

  exp_t exp_q[$];

  dmem_bridge dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: samples on the falling edge, pops an expectation on each DONE.
  initial begin : monitor
    int  sc = 0;
    int  rc = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev = 1'b0; sc = 0; rc = 0;
      end else begin
        if (stall) sc++;
        if (bus_req) begin
          rc++;
          if (exp_q.size() > 0) begin
            check32("bus_we", {31'd0, bus_we}, {31'd0, exp_q[0].we});
            check32("bus_addr", bus_addr, exp_q[0].baddr);
            check32("bus_wdata", bus_wdata, exp_q[0].bwdata);
          end
        end
        if (prev && !stall) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected: completion with empty scoreboard");
          end else begin
            e = exp_q.pop_front();
            check32("rdata", rdata, e.rdata);
            check32("err_done", {31'd0, err}, {31'd0, e.err});
            check32("stall_cycles", sc, e.stalls);
            check32("req_cycles", rc, e.reqs);
            $display("txn baddr=%h we=%0d rdata=%h err=%0d stalls=%0d reqs=%0d",
                     bus_addr, bus_we, rdata, err, sc, rc);
          end
          sc = 0; rc = 0;
        end else begin
          check32("err_idle", {31'd0, err}, 32'd0);
        end
        prev = stall;
      end
    end
  end

  // One core access. ack_at: REQ cycle carrying bus_ack (0 = never).
  // abort_at: REQ cycle in which reset is asserted (0 = none).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_at,
                        input logic [31:0] bdata, input int abort_at,
                        input logic [31:0] e_rdata, input logic e_err,
                        input int e_stalls, input int e_reqs);
    exp_t e;
    int nreq = 0;
    int first_req = 0;
    int n = 0;
    bit done = 0;
    e.rdata = e_rdata; e.err = e_err; e.stalls = e_stalls; e.reqs = e_reqs;
    e.we = wr; e.baddr = {a[31:2], 2'b00}; e.bwdata = wd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    memread = rd; memwrite = wr; addr = a; wdata = wd;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      if (bus_req) begin
        nreq++;
        if (nreq == 1) first_req = n;
        if (abort_at != 0 && nreq == abort_at) begin
          #2 reset = 1'b0;
          memread = 1'b0; memwrite = 1'b0;
          #1;
          check32("abort_bus_req", {31'd0, bus_req}, 32'd0);
          check32("abort_rdata", rdata, 32'd0);
          void'(exp_q.pop_back());
          @(negedge clk);
          @(posedge clk); #1 reset = 1'b1;
          return;
        end
        bus_ack = (ack_at != 0 && nreq == ack_at);
        bus_rdata = bdata;
      end else if (!stall) begin
        done = 1;
      end
    end
    bus_ack = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL access_timeout: no completion within 100 cycles");
    end else if (e_reqs > 0) begin
      check32("req_latency", first_req, 2);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check32("rst_rdata", rdata, 32'd0);
    check32("rst_err", {31'd0, err}, 32'd0);
    check32("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check32("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check32("rst_bus_addr", bus_addr, 32'd0);
    check32("rst_bus_wdata", bus_wdata, 32'd0);
    check32("rst_stall", {31'd0, stall}, 32'd0);

    // load, immediate ack
    access(1, 0, 32'h40, 32'h0, 1, 32'h1234_5678, 0, 32'h1234_5678, 0, 2, 1);
    idle();
    // store, ack on third REQ cycle; rdata unchanged
    access(0, 1, 32'h80, 32'hCAFE_F00D, 3, 32'h0, 0, 32'h1234_5678, 0, 4, 3);
    idle();
    // load, no ack: watchdog expiry
    access(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 32'hDEAD_BEEF, 1, 17, 16);
    idle();
    // ack coinciding with last watchdog cycle: ack wins
    access(1, 0, 32'h104, 32'h0, 16, 32'h7777_7777, 0, 32'h7777_7777, 0, 17, 16);
    idle();
    // reset during the third REQ cycle, then a normal load
    access(1, 0, 32'h44, 32'h0, 0, 32'h0, 3, 32'h0, 0, 0, 0);
    idle();
    access(1, 0, 32'hC0, 32'h0, 1, 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0, 2, 1);
    idle();
    // misaligned load
`ifdef DMEM_ALIGN_CHECK_EN
    access(1, 0, 32'h41, 32'h0, 1, 32'h55AA_55AA, 0, 32'hDEAD_BEEF, 1, 1, 0);
`else
    access(1, 0, 32'h41, 32'h0, 1, 32'h55AA_55AA, 0, 32'h55AA_55AA, 0, 2, 1);
`endif
    idle();
    // back-to-back loads, then a store with both strobes high
    access(1, 0, 32'h200, 32'h0, 1, 32'h1111_1111, 0, 32'h1111_1111, 0, 2, 1);
    access(1, 0, 32'h204, 32'h0, 1, 32'h2222_2222, 0, 32'h2222_2222, 0, 2, 1);
    access(1, 1, 32'h300, 32'hA5A5_A5A5, 1, 32'h9999_9999, 0, 32'h2222_2222, 0, 2, 1);
    idle();

    repeat (4) @(negedge clk);
    check32("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the single-cycle MIPS core and a multi-cycle data bus. It takes the core's load/store request (ALU address, store data, `memread`/`memwrite`) and runs one request/acknowledge transaction on the bus. It holds the core with `stall` until the load data or store completion is available. A watchdog counter bounds every transaction so that a missing `bus_ack` cannot hang the core.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles spent in REQ waiting for `bus_ack` (legal range 1..255).
- `ERRDATA`, default 32'hDEAD_BEEF: value returned on `rdata` when a load times out.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `memread`  in  1  core requests a load this instruction.
- `memwrite`  in  1  core requests a store this instruction (both high at once is treated as a store).
- `addr`  in  32  byte address, from the ALU result.
- `wdata`  in  32  store data, from register read port 2.
- `rdata`  out  32  load data to the core's result mux.
- `stall`  out  1  freeze PC and register-file write while high.
- `err`  out  1  one-cycle pulse on timeout or misalignment.
- `bus_req`  out  1  transaction request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  32  word address on the bus.
- `bus_wdata`  out  32  write data.
- `bus_rdata`  in  32  read data; valid when `bus_ack` is high.
- `bus_ack`  in  1  transaction complete.

## Operation
- States: IDLE, REQ, DONE.
- IDLE:
  - With `memread|memwrite`: latch `addr`, `wdata` and the write flag; clear the watchdog; go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `bus_req`=1; `bus_we`, `bus_addr` and `bus_wdata` come from the latched values and are stable for the whole state.
  - On `bus_ack`: for a load, capture `bus_rdata` into `rdata`; go to DONE.
  - With no ack, increment the watchdog. When the count reaches `TIMEOUT`, go to DONE, set `rdata`=`ERRDATA` (loads only) and pulse `err`.
- DONE: `bus_req`=0; `rdata` is held; go to IDLE unconditionally.
- `stall` is combinational: `(IDLE && (memread|memwrite)) || REQ`. It is 0 in DONE, so the core retires the instruction at the end of the DONE cycle. Returning to IDLE afterwards prevents the same instruction from re-triggering.
- A store leaves `rdata` unchanged.
- `bus_ack` outside REQ is ignored.
- Watchdog width is 8 bits; comparison is `count == TIMEOUT-1` while no ack. If ack and timeout coincide, ack wins with no `err`.

## Timing
- Reset values: state IDLE, `rdata`=0, `err`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, watchdog 0. `stall` follows its combinational equation.
- Access stalls are cycles in which `stall`=1, before the access completes:
  - Best case, ack on the first REQ cycle: 2 stall cycles, plus 1 completion cycle (DONE).
  - Each extra REQ cycle without ack adds 1 stall cycle.
  - Timeout: 1 + `TIMEOUT` stall cycles.
- `err` is registered; it is high during the single DONE cycle only.
- Reset asserted mid-transaction returns the block to IDLE immediately: `bus_req` drops asynchronously and any pending ack is discarded.
- Back-to-back memory instructions: DONE → IDLE → new REQ. There is no bubble beyond the mandatory IDLE detection cycle.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a request with `addr[1:0]`≠0 does not enter REQ. The block goes directly to DONE with `err`=1, and `rdata`=`ERRDATA` for a load.
  - No bus activity occurs; `stall` is high for 1 cycle.
- Not defined: no check; `bus_addr` = {`addr[31:2]`, 2'b00}.
- Aligned accesses behave identically in both builds.

## Test plan
- Load, addr 0x0000_0040, `bus_ack` on the first REQ cycle with `bus_rdata`=0x1234_5678 → `bus_req` for 1 cycle with `bus_we`=0 and `bus_addr`=0x40. `stall` high for 2 cycles; `rdata`=0x1234_5678 in DONE; `err`=0.
- Store, addr 0x80, `wdata`=0xCAFE_F00D, ack after 3 REQ cycles → `bus_we`=1 and `bus_wdata` stable for all 3 cycles. `stall` high for 4 cycles; `rdata` unchanged.
- Load with no ack, `TIMEOUT`=16 → `bus_req` high for exactly 16 cycles; `err` pulses for 1 cycle; `rdata`=0xDEAD_BEEF; `stall` high for 17 cycles.
- Reset driven low during the third REQ cycle, then released → `bus_req`=0 immediately; `rdata`=0; a following load completes normally.
- Misaligned load at addr 0x41:
  - With `DMEM_ALIGN_CHECK_EN`: no `bus_req`; `err` pulses; `stall` high for 1 cycle.
  - Without it: `bus_addr`=0x40 and a normal transaction.
- Two consecutive loads, each acked immediately → the second `bus_req` rises exactly 2 cycles after the first DONE; both data words are returned in order.
